iter_alu: RTL and testbench

Parametrised, handshaked successor to the combinational RV32I ALU. Executes the base integer ALU operations in one registered cycle and adds iterative unsigned multiply and divide (MUL, MULHU, DIVU, REMU) over WIDTH cycles. It sits between decode/operand fetch and writeback. Valid/ready handshakes on both sides let the pipeline stall while a long operation is in flight.

---
 rtl/iter_alu_if.sv | 25 ++
 rtl/iter_alu.sv | 202 ++++++++++++++++++++
 tb/tb_iter_alu.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/iter_alu_if.sv
// rtl/iter_alu_if.sv - request/response handshake bundle for iter_alu
interface iter_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [2:0]       brop;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             branch_enable;

    modport master (
        output in_valid, op, brop, a, b, out_ready,
        input  in_ready, out_valid, result, branch_enable
    );

    modport slave (
        input  in_valid, op, brop, a, b, out_ready,
        output in_ready, out_valid, result, branch_enable
    );
endinterface

// File: rtl/iter_alu.sv
// rtl/iter_alu.sv - handshaked RV32I-style ALU with iterative unsigned mul/div
module iter_alu #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    iter_alu_if.slave  bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_SLT   = 4'd4;
    localparam logic [3:0] OP_SLTU  = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLL   = 4'd8;
    localparam logic [3:0] OP_XOR   = 4'd9;
    localparam logic [3:0] OP_PASSA = 4'd10;
    localparam logic [3:0] OP_ANDN  = 4'd11;
    localparam logic [3:0] OP_MUL   = 4'd12;
    localparam logic [3:0] OP_MULHU = 4'd13;
    localparam logic [3:0] OP_DIVU  = 4'd14;
    localparam logic [3:0] OP_REMU  = 4'd15;

    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;
    localparam logic [2:0] BR_BLTU = 3'd5;
    localparam logic [2:0] BR_BGEU = 3'd6;

    logic [1:0]         state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               br_q, br_d;

    logic               in_ready;
    logic               accept;
    logic [SHAMT_W-1:0] shamt;
    logic               lt_s, lt_u, b_zero;
    logic [WIDTH-1:0]   alu_res;
    logic               br_calc;
    logic               single_cycle;
    logic               is_mul_in, is_mul_q;

    assign in_ready = !reset && ((state_q == ST_IDLE) ||
                                 ((state_q == ST_DONE) && bus.out_ready));
    assign accept   = bus.in_valid && in_ready;

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = (state_q == ST_DONE);
    assign bus.result        = result_q;
    assign bus.branch_enable = br_q;

    assign shamt  = bus.b[SHAMT_W-1:0];
    assign lt_s   = $signed(bus.a) < $signed(bus.b);
    assign lt_u   = bus.a < bus.b;
    assign b_zero = (bus.b == '0);

    assign is_mul_in    = (bus.op == OP_MUL) || (bus.op == OP_MULHU);
    assign is_mul_q     = (op_q == OP_MUL) || (op_q == OP_MULHU);
    // Divide-by-zero has a defined answer, so it completes like a plain ALU op.
    assign single_cycle = (bus.op < OP_MUL) ||
                          (((bus.op == OP_DIVU) || (bus.op == OP_REMU)) && b_zero);

    always_comb begin
        alu_res = '0;
        case (bus.op)
            OP_AND:   alu_res = bus.a & bus.b;
            OP_OR:    alu_res = bus.a | bus.b;
            OP_ADD:   alu_res = bus.a + bus.b;
            OP_SUB:   alu_res = bus.a - bus.b;
            OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, lt_u};
            OP_SRL:   alu_res = bus.a >> shamt;
            OP_SRA:   alu_res = $unsigned($signed(bus.a) >>> shamt);
            OP_SLL:   alu_res = bus.a << shamt;
            OP_XOR:   alu_res = bus.a ^ bus.b;
            OP_PASSA: alu_res = bus.a;
            OP_ANDN:  alu_res = ~bus.a & bus.b;
            OP_DIVU:  alu_res = '1;
            OP_REMU:  alu_res = bus.a;
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        br_calc = 1'b0;
        case (bus.brop)
            BR_BEQ:  br_calc = (bus.a == bus.b);
            BR_BNE:  br_calc = (bus.a != bus.b);
            BR_BLT:  br_calc = lt_s;
            BR_BGE:  br_calc = !lt_s;
            BR_BLTU: br_calc = lt_u;
            BR_BGEU: br_calc = !lt_u;
            default: br_calc = 1'b0;
        endcase
    end

    // Multiply: acc = {partial_high, remaining_multiplier}, shifted right each step.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    // Divide: acc = {remainder, remaining_dividend/quotient}, shifted left each step.
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_new;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                            : {1'b0, acc_q[2*WIDTH-1:1]};

        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, opnd_q};
        q_bit    = !rem_diff[WIDTH];
        rem_new  = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        div_next = {rem_new, acc_q[WIDTH-2:0], q_bit};

        step_next = is_mul_q ? mul_next : div_next;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        br_d     = br_q;

        case (state_q)
            ST_IDLE: ;
            ST_BUSY: begin
                acc_d = step_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                    case (op_q)
                        OP_MUL:   result_d = step_next[WIDTH-1:0];
                        OP_MULHU: result_d = step_next[2*WIDTH-1:WIDTH];
                        OP_DIVU:  result_d = step_next[WIDTH-1:0];
                        default:  result_d = step_next[2*WIDTH-1:WIDTH];
                    endcase
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            op_d = bus.op;
            br_d = br_calc;
            if (single_cycle) begin
                result_d = alu_res;
                state_d  = ST_DONE;
            end else begin
                state_d = ST_BUSY;
                cnt_d   = '0;
                opnd_d  = is_mul_in ? bus.a : bus.b;
                acc_d   = is_mul_in ? {{WIDTH{1'b0}}, bus.b} : {{WIDTH{1'b0}}, bus.a};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            br_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            br_q     <= br_d;
        end
    end
endmodule

// File: tb/tb_iter_alu.sv
// tb/tb_iter_alu.sv - vector table, directed corner cases and random ops vs a reference model
module tb_iter_alu;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    iter_alu_if #(.WIDTH(32)) bus ();

    iter_alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  brop;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        br;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a - b;
            4'd4:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd5:  return (a < b) ? 32'd1 : 32'd0;
            4'd6:  return a >> b[4:0];
            4'd7:  return $unsigned($signed(a) >>> b[4:0]);
            4'd8:  return a << b[4:0];
            4'd9:  return a ^ b;
            4'd10: return a;
            4'd11: return ~a & b;
            4'd12: return p[31:0];
            4'd13: return p[63:32];
            4'd14: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic ref_br(input logic [2:0] brop, input logic [31:0] a, input logic [31:0] b);
        case (brop)
            3'd1: return a == b;
            3'd2: return a != b;
            3'd3: return $signed(a) < $signed(b);
            3'd4: return $signed(a) >= $signed(b);
            3'd5: return a < b;
            3'd6: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
        if (op == 4'd12 || op == 4'd13) return 33;
        if ((op == 4'd14 || op == 4'd15) && b != 0) return 33;
        return 1;
    endfunction

    // Issue one request, count edges until out_valid, then consume the result.
    task automatic do_op(input logic [3:0] op, input logic [2:0] brop,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic br,
                         output int lat, output logic busy_ok);
        int guard;
        @(negedge clk);
        bus.op = op; bus.brop = brop; bus.a = a; bus.b = b;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.op = 4'($urandom); bus.brop = 3'($urandom);
        lat = 1;
        busy_ok = 1'b1;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        res = bus.result;
        br = bus.branch_enable;
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        logic        br, busy_ok;
        int          lat;
        logic [3:0]  op;
        logic [2:0]  brop;
        logic [31:0] a, b;

        vecs[0]  = '{4'd2,  3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1};
        vecs[1]  = '{4'd3,  3'd1, 32'd5,         32'd5,         32'd0,         1'b1, 1};
        vecs[2]  = '{4'd2,  3'd5, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b1, 1};
        vecs[3]  = '{4'd2,  3'd3, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0, 1};
        vecs[4]  = '{4'd7,  3'd0, 32'h8000_0000, 32'd36,        32'hF800_0000, 1'b0, 1};
        vecs[5]  = '{4'd8,  3'd0, 32'd1,         32'd31,        32'h8000_0000, 1'b0, 1};
        vecs[6]  = '{4'd5,  3'd0, 32'd0,         32'd1,         32'd1,         1'b0, 1};
        vecs[7]  = '{4'd12, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33};
        vecs[8]  = '{4'd13, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 33};
        vecs[9]  = '{4'd14, 3'd6, 32'd100,       32'd7,         32'd14,        1'b1, 33};
        vecs[10] = '{4'd15, 3'd0, 32'd100,       32'd7,         32'd2,         1'b0, 33};
        vecs[11] = '{4'd14, 3'd2, 32'd9,         32'd0,         32'hFFFF_FFFF, 1'b1, 1};
        vecs[12] = '{4'd15, 3'd0, 32'd9,         32'd0,         32'd9,         1'b0, 1};

        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op = 4'd0; bus.brop = 3'd0; bus.a = 32'd0; bus.b = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_branch", 32'(bus.branch_enable), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 13; i++) begin
            do_op(vecs[i].op, vecs[i].brop, vecs[i].a, vecs[i].b, res, br, lat, busy_ok);
            chk($sformatf("vec%0d_result", i), res, vecs[i].res);
            chk($sformatf("vec%0d_branch", i), 32'(br), 32'(vecs[i].br));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            if (vecs[i].lat > 1) chk($sformatf("vec%0d_busy_in_ready", i), 32'(busy_ok), 32'd1);
        end

        // Backpressure on an ADD, then consume and accept an XOR in the same edge.
        @(negedge clk);
        bus.op = 4'd2; bus.brop = 3'd0; bus.a = 32'd2; bus.b = 32'd3; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("bp_first_valid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp_hold%0d_result", i), bus.result, 32'd5);
            chk($sformatf("bp_hold%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        bus.op = 4'd9; bus.a = 32'hF0F0_F0F0; bus.b = 32'hFF00_FF00;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        chk("b2b_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b_result", bus.result, 32'h0FF0_0FF0);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;

        // Reset while a divide is iterating.
        @(negedge clk);
        bus.op = 4'd14; bus.a = 32'd100; bus.b = 32'd7; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_result", bus.result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        do_op(4'd2, 3'd0, 32'd2, 32'd3, res, br, lat, busy_ok);
        chk("midrst_add_result", res, 32'd5);
        chk("midrst_add_latency", 32'(lat), 32'd1);

        for (int i = 0; i < 40; i++) begin
            op   = 4'($urandom_range(0, 15));
            brop = 3'($urandom_range(0, 7));
            a    = $urandom;
            case ($urandom_range(0, 2))
                0: b = $urandom;
                1: b = 32'($urandom_range(0, 15));
                default: b = a;
            endcase
            do_op(op, brop, a, b, res, br, lat, busy_ok);
            chk($sformatf("rnd%0d_op%0d_result", i, op), res, ref_res(op, a, b));
            chk($sformatf("rnd%0d_brop%0d_branch", i, brop), 32'(br), 32'(ref_br(brop, a, b)));
            chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(ref_lat(op, b)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
